ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 6000, sets the clock-inhibit duration in clk_sys cycles (120 us at 50 MHz).
REQ-002 Parameter START_TO_CYC, default 750000, sets the maximum wait for the first device clock edge (15 ms).
REQ-003 Parameter XFER_TO_CYC, default 100000, sets the maximum time from the first device edge to ACK (2 ms).
REQ-004 Parameter FILT_CYC, default 8, sets the number of consecutive stable samples needed for a PS2 line level change.
REQ-005 clk_sys  in  1  system clock; all logic is single-clock on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  command write strobe.
REQ-008 wr_data  in  8  command byte.
REQ-009 wr_rdy  out  1  high only in IDLE; a write is accepted when wr_en and wr_rdy are both high.
REQ-010 tx_busy  out  1  high from write acceptance until the done pulse; the receiver is gated with it.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  2  status, valid with done: 00 ok, 01 no ACK, 10 start timeout, 11 transfer timeout.
REQ-013 PS2_CLK_IN, PS2_DATA_IN  in  1 each  raw pad levels.
REQ-014 PS2_CLK_OE, PS2_DATA_OE  out  1 each  1 drives the pad low; 0 releases it (open-drain).

Function
REQ-015 Both PS2 inputs SHALL pass a 2-flop synchronizer and then a FILT_CYC stability filter; the device edge is a filtered clock 1->0 transition.
REQ-016 FSM states: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-017 On acceptance: latch wr_data, compute odd parity as the inverse XOR-reduce of the byte, enter INHIBIT on the next cycle, and drop wr_rdy on that cycle.
REQ-018 INHIBIT: CLK_OE=1 and DATA_OE=0 for exactly INHIBIT_CYC cycles, then enter START.
REQ-019 START: CLK_OE=0 and DATA_OE=1 (start bit); the first device edge presents bit0 and enters SHIFT.
REQ-020 SHIFT: each device edge presents the next bit (bits 1..7, then parity, then stop); DATA_OE is the inverse of the bit, and stop gives DATA_OE=0.
REQ-021 A 4-bit counter tracks edges; the edge after the stop bit is presented moves the FSM to ACK.
REQ-022 ACK: on the next device edge, sample the filtered data line; 0 means err=00, 1 means err=01; then enter WAIT_IDLE.
REQ-023 WAIT_IDLE: when filtered clock and data are both high, pulse done for one cycle with err, then return to IDLE; wr_rdy rises on the cycle after done.
REQ-024 The START_TO_CYC counter runs in START; on expiry, release both lines and pulse done with err=10.
REQ-025 The XFER_TO_CYC counter runs from SHIFT entry through ACK; on expiry, release both lines and pulse done with err=11.
REQ-026 A device edge and a timeout expiring in the same cycle SHALL resolve as the timeout.
REQ-027 wr_en while wr_rdy=0 SHALL be ignored, with no queueing and no side effect.
REQ-028 Outside INHIBIT/START/SHIFT, both OE outputs SHALL be 0.

Reset
REQ-029 While rst is high at a clk_sys edge: state=IDLE, CLK_OE=0, DATA_OE=0, wr_rdy=0, tx_busy=0, done=0, err=00, counters and filters cleared to the idle-high level.
REQ-030 wr_rdy SHALL go to 1 on the first edge after rst deasserts.
REQ-031 Reset mid-transfer SHALL release both lines on that same edge, with no done pulse.

Structure
REQ-032 Package ps2_pkg SHALL hold the state enum, the err code constants, and the command constants CMD_RESET=8'hFF, CMD_EN_REPORT=8'hF4, and DEV_ACK=8'hFA.
REQ-033 The synchronizer, stability filter and falling-edge detect SHALL be one sub-module, ps2_line_filter, instantiated once per line.

Verification (INHIBIT_CYC=20, START_TO_CYC=400, XFER_TO_CYC=4000, FILT_CYC=2; device model clock period 200 cycles)
REQ-034 Write 8'hF4 with the model ACKing -> CLK_OE high 20 cycles; bits seen 0,0,1,0,1,1,1,1, parity 0, stop 1; done with err=00.
REQ-035 Write 8'hFF with the model ACKing -> parity bit 1; done with err=00; wr_rdy high the cycle after done.
REQ-036 Write 8'hF4 with the model holding data high at the ACK edge -> done with err=01.
REQ-037 Write with the model never clocking -> 400 cycles after START, both OE=0 and done with err=10.
REQ-038 Model stops clocking after bit 3 -> done with err=11; a second wr_en during the transfer is ignored.
REQ-039 Assert rst during SHIFT -> both OE=0 on that edge, no done pulse, wr_rdy=1 one edge after release.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-to-device command transmitter:
//   - ps2_state_t  : transmitter FSM state encoding
//   - ERR_*        : completion status codes reported on err with done
//   - CMD_* / DEV_*: common mouse/keyboard command and response bytes
//   - FRAME_BITS   : number of host-driven bits (8 data + parity + stop)
//   - odd_parity() : parity bit that makes the 9-bit data+parity word odd
//   - max3()       : elaboration-time helper used to size shared timers
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_NO_ACK   = 2'b01;
    localparam logic [1:0] ERR_START_TO = 2'b10;
    localparam logic [1:0] ERR_XFER_TO  = 2'b11;

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_EN_REPORT = 8'hF4;
    localparam logic [7:0] DEV_ACK       = 8'hFA;

    // data bits 0..7, parity, stop
    localparam int FRAME_BITS = 10;

    // Odd parity: the parity bit is set when the byte has an even number of ones.
    function automatic logic odd_parity(input logic [7:0] data_byte);
        return ~(^data_byte);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 pad level for use in the clk_sys domain:
// a 2-flop synchronizer followed by a stability filter that only accepts a
// new level after FILT_CYC consecutive identical samples, plus a one-cycle
// strobe on each filtered 1->0 transition.
//
// Ports
//   clk_sys    in   system clock
//   rst        in   synchronous active-high reset (line returns to idle-high)
//   line_raw   in   asynchronous pad level
//   line_filt  out  filtered level
//   line_fall  out  one-cycle pulse, coincident with line_filt going 1->0
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILT_CYC = 8
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic line_raw,
    output logic line_filt,
    output logic line_fall
);

    localparam int              CNT_W    = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             filt_reg;
    logic             fall_reg;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync_reg <= 2'b11;
            cnt_reg  <= '0;
            filt_reg <= 1'b1;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], line_raw};
            fall_reg <= 1'b0;
            if (sync_reg[1] != filt_reg) begin
                // cnt_reg counts how many consecutive samples already
                // disagreed; the current one completes the run at CNT_LAST.
                if (cnt_reg == CNT_LAST) begin
                    filt_reg <= sync_reg[1];
                    cnt_reg  <= '0;
                    // a change away from a high level is by definition a fall
                    fall_reg <= filt_reg;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign line_filt = filt_reg;
    assign line_fall = fall_reg;

endmodule

// File: rtl/ps2_tx.sv
// ---------------------------------------------------------------------------
// ps2_tx
// PS/2 host-to-device command transmitter. A byte written on wr_data is sent
// using the host-initiated PS/2 sequence: inhibit the clock, request-to-send
// (data low), then present each bit after every device clock fall, and
// finally sample the device ACK. Start and transfer watchdogs abort the
// sequence with a status code.
//
// Ports
//   clk_sys      in   system clock, all logic on its rising edge
//   rst          in   synchronous active-high reset
//   wr_en        in   command write strobe
//   wr_data[7:0] in   command byte
//   wr_rdy       out  ready for a write (IDLE only)
//   tx_busy      out  transfer in progress (gates the companion receiver)
//   done         out  one-cycle completion pulse
//   err[1:0]     out  completion status, valid with done (see ERR_*)
//   PS2_CLK_IN   in   raw clock pad level
//   PS2_DATA_IN  in   raw data pad level
//   PS2_CLK_OE   out  1 pulls the clock pad low, 0 releases it
//   PS2_DATA_OE  out  1 pulls the data pad low, 0 releases it
// ---------------------------------------------------------------------------
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC  = 6000,
    parameter int START_TO_CYC = 750000,
    parameter int XFER_TO_CYC  = 100000,
    parameter int FILT_CYC     = 8
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       wr_rdy,
    output logic       tx_busy,
    output logic       done,
    output logic [1:0] err,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE
);

    // One timer serves INHIBIT, START and SHIFT/ACK because those phases never
    // overlap; it is sized for the longest of the three intervals.
    localparam int TMR_MAX = max3(INHIBIT_CYC, START_TO_CYC, XFER_TO_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INHIBIT_CYC - 1);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TO_CYC - 1);
    localparam logic [TMR_W-1:0] XFER_LAST  = TMR_W'(XFER_TO_CYC - 1);
    localparam logic [3:0]       STOP_DONE  = 4'(FRAME_BITS);

    // ------------------------------------------------------------------
    // Line conditioning
    // ------------------------------------------------------------------
    logic clk_filt;
    logic clk_fall;
    logic data_filt;
    logic unused_data_fall;

    ps2_line_filter #(
        .FILT_CYC (FILT_CYC)
    ) u_clk_filter (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .line_raw  (PS2_CLK_IN),
        .line_filt (clk_filt),
        .line_fall (clk_fall)
    );

    ps2_line_filter #(
        .FILT_CYC (FILT_CYC)
    ) u_data_filter (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .line_raw  (PS2_DATA_IN),
        .line_filt (data_filt),
        .line_fall (unused_data_fall)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    ps2_state_t            state_reg;
    logic [TMR_W-1:0]      tmr_reg;
    logic [3:0]            bit_cnt_reg;
    logic [FRAME_BITS-1:0] frame_reg;
    logic                  clk_oe_reg;
    logic                  data_oe_reg;
    logic                  wr_rdy_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [1:0]            err_reg;

    // Watchdog expiry is evaluated before any device edge handling so that
    // an edge landing on the expiry cycle is resolved as the timeout.
    logic       tmo_hit;
    logic [1:0] tmo_code;

    always_comb begin
        tmo_hit  = 1'b0;
        tmo_code = ERR_OK;
        if (state_reg == ST_START && tmr_reg == START_LAST) begin
            tmo_hit  = 1'b1;
            tmo_code = ERR_START_TO;
        end else if ((state_reg == ST_SHIFT || state_reg == ST_ACK) &&
                     tmr_reg == XFER_LAST) begin
            tmo_hit  = 1'b1;
            tmo_code = ERR_XFER_TO;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            tmr_reg     <= '0;
            bit_cnt_reg <= '0;
            frame_reg   <= '0;
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            wr_rdy_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= ERR_OK;
        end else begin
            done_reg <= 1'b0;

            if (tmo_hit) begin
                // Abort: release both pads and report. Going through IDLE
                // with wr_rdy low delays ready by one cycle after done.
                clk_oe_reg  <= 1'b0;
                data_oe_reg <= 1'b0;
                done_reg    <= 1'b1;
                err_reg     <= tmo_code;
                busy_reg    <= 1'b0;
                wr_rdy_reg  <= 1'b0;
                state_reg   <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        if (wr_en && wr_rdy_reg) begin
                            frame_reg  <= {1'b1, odd_parity(wr_data), wr_data};
                            tmr_reg    <= '0;
                            err_reg    <= ERR_OK;
                            wr_rdy_reg <= 1'b0;
                            busy_reg   <= 1'b1;
                            clk_oe_reg <= 1'b1;
                            state_reg  <= ST_INHIBIT;
                        end else begin
                            wr_rdy_reg <= 1'b1;
                        end
                    end

                    ST_INHIBIT: begin
                        if (tmr_reg == INH_LAST) begin
                            // release the clock and assert the start bit
                            clk_oe_reg  <= 1'b0;
                            data_oe_reg <= 1'b1;
                            tmr_reg     <= '0;
                            state_reg   <= ST_START;
                        end else begin
                            tmr_reg <= tmr_reg + TMR_W'(1);
                        end
                    end

                    ST_START: begin
                        if (clk_fall) begin
                            data_oe_reg <= ~frame_reg[0];
                            bit_cnt_reg <= 4'd1;
                            tmr_reg     <= '0;
                            state_reg   <= ST_SHIFT;
                        end else begin
                            tmr_reg <= tmr_reg + TMR_W'(1);
                        end
                    end

                    ST_SHIFT: begin
                        tmr_reg <= tmr_reg + TMR_W'(1);
                        if (clk_fall) begin
                            if (bit_cnt_reg == STOP_DONE) begin
                                // stop bit has been clocked out; free the
                                // data line so the device can ACK on it
                                data_oe_reg <= 1'b0;
                                state_reg   <= ST_ACK;
                            end else begin
                                data_oe_reg <= ~frame_reg[bit_cnt_reg];
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end

                    ST_ACK: begin
                        data_oe_reg <= 1'b0;
                        tmr_reg     <= tmr_reg + TMR_W'(1);
                        if (clk_fall) begin
                            err_reg   <= data_filt ? ERR_NO_ACK : ERR_OK;
                            state_reg <= ST_WAIT_IDLE;
                        end
                    end

                    ST_WAIT_IDLE: begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        // the device must release both lines before the bus
                        // is considered free again
                        if (clk_filt && data_filt) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end

                    default: begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_rdy      = wr_rdy_reg;
    assign tx_busy     = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign PS2_CLK_OE  = clk_oe_reg;
    assign PS2_DATA_OE = data_oe_reg;

endmodule

// File: tb/tb_ps2_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_tx
// Self-checking bench for ps2_tx with a behavioural PS/2 device on the pads.
// Expected completion codes are queued when a command is written and popped
// when done pulses.
// ---------------------------------------------------------------------------
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int STO  = 400;
    localparam int XTO  = 4000;
    localparam int FC   = 2;
    localparam int HALF = 100;   // device clock period = 200 cycles

    logic       clk_sys = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_rdy;
    logic       tx_busy;
    logic       done;
    logic [1:0] err;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       ps2_clk_in;
    logic       ps2_data_in;

    // device-side open-drain drivers; 1 = released
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk_sys = ~clk_sys;

    ps2_tx #(
        .INHIBIT_CYC  (INH),
        .START_TO_CYC (STO),
        .XFER_TO_CYC  (XTO),
        .FILT_CYC     (FC)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_rdy      (wr_rdy),
        .tx_busy     (tx_busy),
        .done        (done),
        .err         (err),
        .PS2_CLK_IN  (ps2_clk_in),
        .PS2_DATA_IN (ps2_data_in),
        .PS2_CLK_OE  (ps2_clk_oe),
        .PS2_DATA_OE (ps2_data_oe)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard and monitors
    // ------------------------------------------------------------------
    logic [1:0] exp_err_q[$];
    int   done_cnt    = 0;
    int   inh_run     = 0;
    int   inh_len     = 0;
    int   inh_starts  = 0;
    logic rdy_pending = 1'b0;

    always @(negedge clk_sys) begin
        if (rdy_pending) begin
            check_eq("rdy_after_done", {31'd0, wr_rdy}, 32'd1);
            rdy_pending = 1'b0;
        end
        if (!rst && done) begin
            done_cnt++;
            check_eq("rdy_low_on_done", {31'd0, wr_rdy}, 32'd0);
            check_eq("oe_released_on_done", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            if (exp_err_q.size() == 0) begin
                check_eq("done_unexpected", exp_err_q.size(), 32'd1);
            end else begin
                logic [1:0] e;
                e = exp_err_q.pop_front();
                check_eq("done_err", {30'd0, err}, {30'd0, e});
                $display("[TB] done err=%b expected=%b", err, e);
            end
            rdy_pending = 1'b1;
        end
        if (ps2_clk_oe) begin
            if (inh_run == 0) inh_starts++;
            inh_run++;
        end else begin
            if (inh_run != 0) inh_len = inh_run;
            inh_run = 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_rdy();
        int n;
        n = 0;
        while (!wr_rdy && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        if (!wr_rdy) check_eq("wr_rdy_timeout", {31'd0, wr_rdy}, 32'd1);
    endtask

    task automatic write_cmd(input logic [7:0] d);
        @(negedge clk_sys);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk_sys);
        wr_en   = 1'b0;
        $display("[TB] write 0x%02h wr_rdy=%b", d, wr_rdy);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        if (done_cnt < target) check_eq("done_timeout", done_cnt, target);
    endtask

    // Device: waits for request-to-send, then issues nfalls clock pulses,
    // sampling the data pad mid-high. Before the 12th fall (the ACK edge) it
    // drives data to ack_lvl.
    task automatic run_device(input int nfalls, input logic ack_lvl, output logic [11:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        if (!(ps2_data_oe && !ps2_clk_oe)) begin
            check_eq("start_seen", {31'd0, ps2_data_oe}, 32'd1);
            return;
        end
        repeat (50) @(negedge clk_sys);
        for (int i = 0; i < nfalls; i++) begin
            if (i == 11) begin
                dev_data = ack_lvl;
                repeat (HALF / 2) @(negedge clk_sys);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk_sys);
            dev_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk_sys);
            bits[i] = ps2_data_in;
            repeat (HALF / 2) @(negedge clk_sys);
        end
        dev_data = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [11:0] bits;
        int          n;
        int          base;
        int          starts;

        // reset state
        repeat (4) @(negedge clk_sys);
        check_eq("rst_wr_rdy", {31'd0, wr_rdy}, 32'd0);
        check_eq("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check_eq("rst_busy_done", {30'd0, tx_busy, done}, 32'd0);
        check_eq("rst_err", {30'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk_sys);
        check_eq("rdy_first_edge", {31'd0, wr_rdy}, 32'd1);

        // 0xF4 with ACK
        base = done_cnt;
        exp_err_q.push_back(ERR_OK);
        write_cmd(CMD_EN_REPORT);
        check_eq("accept_busy", {31'd0, tx_busy}, 32'd1);
        check_eq("accept_rdy_low", {31'd0, wr_rdy}, 32'd0);
        check_eq("inhibit_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b10);
        run_device(12, 1'b0, bits);
        check_eq("f4_frame", {22'd0, bits[9:0]}, 32'h2F4);
        check_eq("inhibit_len", inh_len, INH);
        wait_done(base + 1, 2000);

        // 0xFF with ACK: parity bit must be 1
        wait_rdy();
        base = done_cnt;
        exp_err_q.push_back(ERR_OK);
        write_cmd(CMD_RESET);
        run_device(12, 1'b0, bits);
        check_eq("ff_parity", {31'd0, bits[8]}, 32'd1);
        check_eq("ff_frame", {22'd0, bits[9:0]}, 32'h3FF);
        wait_done(base + 1, 2000);

        // 0xF4 with no ACK
        wait_rdy();
        base = done_cnt;
        exp_err_q.push_back(ERR_NO_ACK);
        write_cmd(CMD_EN_REPORT);
        run_device(12, 1'b1, bits);
        wait_done(base + 1, 2000);

        // device never clocks: start timeout
        wait_rdy();
        base = done_cnt;
        exp_err_q.push_back(ERR_START_TO);
        write_cmd(CMD_RESET);
        n = 0;
        while (!ps2_data_oe && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq("start_entered", {31'd0, ps2_data_oe}, 32'd1);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq("start_to_cycles", n, STO);
        wait_done(base + 1, 10);

        // device stops after bit 3: transfer timeout; extra write ignored
        wait_rdy();
        base = done_cnt;
        exp_err_q.push_back(ERR_XFER_TO);
        write_cmd(CMD_EN_REPORT);
        run_device(4, 1'b0, bits);
        check_eq("partial_bits", {28'd0, bits[3:0]}, 32'h4);
        write_cmd(8'h00);
        check_eq("ignored_busy", {31'd0, tx_busy}, 32'd1);
        check_eq("ignored_rdy", {31'd0, wr_rdy}, 32'd0);
        wait_done(base + 1, 6000);
        starts = inh_starts;
        repeat (600) @(negedge clk_sys);
        check_eq("no_queued_xfer", inh_starts, starts);
        check_eq("no_extra_done", done_cnt, base + 1);

        // reset during SHIFT
        wait_rdy();
        base = done_cnt;
        write_cmd(CMD_EN_REPORT);
        run_device(3, 1'b0, bits);
        @(negedge clk_sys);
        rst = 1'b1;
        @(negedge clk_sys);
        check_eq("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_rdy", {31'd0, wr_rdy}, 32'd0);
        @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        check_eq("midrst_rdy_release", {31'd0, wr_rdy}, 32'd1);
        repeat (50) @(negedge clk_sys);
        check_eq("midrst_no_done", done_cnt, base);
        $display("[TB] reset during shift, oe released");

        check_eq("sb_empty", exp_err_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
